// File: rtl/clk_divider_prog.sv
// clk_divider_prog
//   Runtime-programmable integer clock divider. Produces a registered,
//   glitch-free divided clock from clk_in. The divisor is loaded through a
//   valid/ready handshake and only takes effect at period boundaries, so the
//   output never shows a truncated high or low phase.
//
//   Each period of N cycles is high for H = N - floor(N/2) cycles, then low
//   for floor(N/2) cycles. Divisor values 0 and 1 are stored as 2.
//
// Ports
//   clk_in          : clock, all logic on its rising edge
//   rst_n_in        : asynchronous active-low reset
//   en_in           : run request, sampled at period boundaries
//   div_in          : requested divisor
//   div_valid_in    : div_in is valid
//   div_ready_out   : a divisor can be accepted (no divisor pending)
//   div_active_out  : divisor currently in force
//   clk_out         : divided clock, registered
//   tick_out        : one-cycle pulse aligned with each clk_out period start
//
// Configuration
//   CLK_DIV_TICK_EN : when defined, adds tick_out and its flop.

module clk_divider_prog #(
    parameter int DIV_WIDTH = 8,
    parameter int DIV_RESET = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 en_in,
    input  logic [DIV_WIDTH-1:0] div_in,
    input  logic                 div_valid_in,
    output logic                 div_ready_out,
    output logic [DIV_WIDTH-1:0] div_active_out,
    output logic                 clk_out
`ifdef CLK_DIV_TICK_EN
    ,
    output logic                 tick_out
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(2);

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] act_q, act_d;
    logic [DIV_WIDTH-1:0] pend_q, pend_d;
    logic                 pend_v_q, pend_v_d;
    logic                 clk_q, clk_d;

    logic                 xfer;
    logic                 boundary;
    logic [DIV_WIDTH-1:0] div_clamped;
    logic [DIV_WIDTH-1:0] next_div;
    logic [DIV_WIDTH-1:0] high_len;
    logic [DIV_WIDTH-1:0] cnt_inc;

    assign xfer        = div_valid_in && !pend_v_q;
    assign div_clamped = (div_in < DIV_MIN) ? DIV_MIN : div_in;
    assign boundary    = (cnt_q == act_q - DIV_WIDTH'(1));
    assign high_len    = act_q - (act_q >> 1);
    assign cnt_inc     = cnt_q + DIV_WIDTH'(1);

    // Divisor for a period starting on this edge: a held pending value wins;
    // otherwise a transfer on this very edge bypasses the pending register.
    assign next_div    = pend_v_q ? pend_q : (xfer ? div_clamped : act_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        act_d    = act_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        clk_d    = clk_q;

        // Capture an accepted divisor; a period start below overrides this
        // by consuming next_div directly.
        if (xfer) begin
            pend_d   = div_clamped;
            pend_v_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                clk_d = 1'b0;
                if (en_in) begin
                    state_d  = RUN;
                    clk_d    = 1'b1;
                    act_d    = next_div;
                    pend_v_d = 1'b0;
                end else if (pend_v_q) begin
                    // Nothing is running, so a held divisor applies at once.
                    act_d    = pend_q;
                    pend_v_d = 1'b0;
                end
            end
            RUN: begin
                if (!boundary) begin
                    cnt_d = cnt_inc;
                    clk_d = (cnt_inc < high_len);
                end else if (!en_in) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    clk_d   = 1'b0;
                end else begin
                    cnt_d    = '0;
                    clk_d    = 1'b1;
                    act_d    = next_div;
                    pend_v_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            act_q    <= DIV_WIDTH'(DIV_RESET);
            pend_q   <= DIV_WIDTH'(DIV_RESET);
            pend_v_q <= 1'b0;
            clk_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            act_q    <= act_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            clk_q    <= clk_d;
        end
    end

    assign div_ready_out  = !pend_v_q;
    assign div_active_out = act_q;
    assign clk_out        = clk_q;

`ifdef CLK_DIV_TICK_EN
    logic tick_q, tick_d;

    // Period start: leaving IDLE, or a boundary edge that keeps running.
    always_comb begin
        tick_d = en_in && ((state_q == IDLE) || boundary);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign tick_out = tick_q;
`endif

endmodule

// File: tb/tb_clk_divider_prog.sv
// Testbench for clk_divider_prog: directed scenarios with literal
// expectations, then randomized traffic, all checked every cycle against a
// queue-based model that expands each period into its list of output levels.

module tb_clk_divider_prog;

    localparam int DW = 8;
    localparam int DR = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [DW-1:0] div = '0;
    logic          valid = 1'b0;
    logic          ready;
    logic [DW-1:0] active;
    logic          clk_o;
`ifdef CLK_DIV_TICK_EN
    logic          tick;
`endif

    int errors = 0;
    int checks = 0;

    clk_divider_prog #(.DIV_WIDTH(DW), .DIV_RESET(DR)) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .en_in         (en),
        .div_in        (div),
        .div_valid_in  (valid),
        .div_ready_out (ready),
        .div_active_out(active),
        .clk_out       (clk_o)
`ifdef CLK_DIV_TICK_EN
        ,
        .tick_out      (tick)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // q holds the clk_out levels still to come in the current period;
    // an empty queue while running means the next edge is a boundary.
    int   q[$];
    bit   m_run  = 0;
    int   m_act  = DR;
    bit   m_pv   = 0;
    int   m_pd   = 0;
    bit   m_clk  = 0;
    bit   m_tick = 0;

    function automatic int clampd(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_run = 0; m_act = DR; m_pv = 0; m_clk = 0; m_tick = 0;
        end else begin
            bit xf;
            int nd;
            xf = valid && !m_pv;
            if (m_run && q.size() > 0) begin
                m_clk = q.pop_front() != 0;
                m_tick = 0;
                if (xf) begin m_pv = 1; m_pd = clampd(int'(div)); end
            end else if (en) begin
                nd = m_pv ? m_pd : (xf ? clampd(int'(div)) : m_act);
                m_act = nd; m_pv = 0; m_run = 1;
                q.delete();
                for (int i = 0; i < nd; i++) q.push_back((i < nd - nd / 2) ? 1 : 0);
                m_clk = q.pop_front() != 0;
                m_tick = 1;
            end else if (m_run) begin
                m_run = 0; m_clk = 0; m_tick = 0;
                if (xf) begin m_pv = 1; m_pd = clampd(int'(div)); end
            end else begin
                m_clk = 0; m_tick = 0;
                if (m_pv) begin m_act = m_pd; m_pv = 0; end
                else if (xf) begin m_pv = 1; m_pd = clampd(int'(div)); end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            chk("clk_out", int'(clk_o), int'(m_clk));
            chk("div_active", int'(active), m_act);
            chk("div_ready", int'(ready), int'(!m_pv));
`ifdef CLK_DIV_TICK_EN
            chk("tick_out", int'(tick), int'(m_tick));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic v, input int d);
        en = e; valid = v; div = DW'(d);
    endtask

    task automatic wait_idle();
        int n;
        drive(0, 0, 0);
        n = 0;
        while (m_run && n < 600) begin nxt(); n++; end
        if (m_run) chk("idle_timeout", 1, 0);
        nxt();
    endtask

    task automatic load(input int d);
        drive(0, 1, d);
        nxt();
        drive(0, 0, 0);
        nxt();
        nxt();
    endtask

    initial begin
        int p5[10] = '{1, 1, 1, 0, 0, 1, 1, 1, 0, 0};
        int pc[11] = '{1, 0, 0, 1, 1, 1, 1, 0, 0, 0, 1};
        int p8[10] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
        int cv[3]  = '{0, 7, 1};
        int ce[3]  = '{2, 7, 2};

        // reset values
        #12;
        chk("rst_clk_out", int'(clk_o), 0);
        chk("rst_ready", int'(ready), 1);
        chk("rst_active", int'(active), 2);
`ifdef CLK_DIV_TICK_EN
        chk("rst_tick", int'(tick), 0);
`endif
        nxt();
        rst_n = 1'b1;

        // default divisor 2: 1,0 repeating, high one edge after enable
        nxt();
        drive(1, 0, 0);
        for (int k = 0; k < 6; k++) begin
            nxt();
            chk("n2_clk", int'(clk_o), (k % 2 == 0) ? 1 : 0);
        end
        chk("n2_active", int'(active), 2);

        // N=5 loaded in IDLE: 3 high / 2 low
        wait_idle();
        load(5);
        chk("n5_active", int'(active), 5);
        drive(1, 0, 0);
        for (int k = 0; k < 10; k++) begin
            nxt();
            chk("n5_clk", int'(clk_o), p5[k]);
`ifdef CLK_DIV_TICK_EN
            chk("n5_tick", int'(tick), (k % 5 == 0) ? 1 : 0);
`endif
        end

        // N=4 running, load 7 mid-period
        wait_idle();
        load(4);
        drive(1, 0, 0);
        nxt();
        drive(1, 1, 7);
        for (int k = 0; k < 11; k++) begin
            nxt();
            if (k == 0) drive(1, 0, 0);
            chk("n4to7_clk", int'(clk_o), pc[k]);
            chk("n4to7_ready", int'(ready), (k < 3) ? 0 : 1);
        end
        chk("n4to7_active", int'(active), 7);

        // N=3 transferred exactly on the boundary edge of an N=6 period
        wait_idle();
        load(6);
        drive(1, 0, 0);
        for (int k = 0; k < 6; k++) begin
            nxt();
            chk("n6_ready", int'(ready), 1);
        end
        drive(1, 1, 3);
        nxt();
        drive(1, 0, 0);
        chk("bnd_active", int'(active), 3);
        chk("bnd_clk", int'(clk_o), 1);
        chk("bnd_ready", int'(ready), 1);
        for (int k = 0; k < 3; k++) begin
            nxt();
            chk("bnd_n3_clk", int'(clk_o), (k == 1) ? 0 : 1);
        end

        // divisor clamp 0 and 1 -> 2
        wait_idle();
        for (int k = 0; k < 3; k++) begin
            load(cv[k]);
            chk("clamp_active", int'(active), ce[k]);
        end
        drive(1, 0, 0);
        nxt();
        chk("clamp_clk_hi", int'(clk_o), 1);
        nxt();
        chk("clamp_clk_lo", int'(clk_o), 0);

        // N=8, drop enable at cnt=1: full period completes, then holds 0
        wait_idle();
        load(8);
        drive(1, 0, 0);
        nxt();
        chk("n8_clk", int'(clk_o), p8[0]);
        nxt();
        chk("n8_clk", int'(clk_o), p8[1]);
        drive(0, 0, 0);
        for (int k = 2; k < 10; k++) begin
            nxt();
            chk("n8_clk", int'(clk_o), p8[k]);
        end

        // async reset during the high phase
        drive(1, 0, 0);
        nxt();
        nxt();
        chk("pre_rst_clk", int'(clk_o), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_clk", int'(clk_o), 0);
        chk("async_rst_active", int'(active), 2);
        chk("async_rst_ready", int'(ready), 1);
        nxt();
        rst_n = 1'b1;

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            nxt();
            en    = ($urandom_range(0, 19) != 0);
            valid = ($urandom_range(0, 3) == 0);
            div   = ($urandom_range(0, 7) == 0) ? DW'($urandom_range(0, 255))
                                                 : DW'($urandom_range(0, 9));
            if (c % 211 == 100) begin
                en = 1'b0;
                repeat (40) nxt();
            end
            if (c % 997 == 500) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rnd_rst_clk", int'(clk_o), 0);
                chk("rnd_rst_active", int'(active), DR);
                nxt();
                rst_n = 1'b1;
            end
        end

        nxt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
